snd_tone_gen: RTL



---
 rtl/snd_common.sv | 13 +
 rtl/snd_tone_gen.sv | 90 +++++++++
 2 files changed

// File: rtl/snd_common.sv
// Shared constants for the CPU sound path: count width, system clock rate,
// and a helper that turns a tone frequency into a half-period count.
package snd_common;

    localparam int unsigned SND_COUNT_WIDTH = 26;
    localparam int unsigned SND_CLK_HZ      = 50_000_000;

    // Half-period in system clocks for a square wave of the given frequency.
    function automatic int unsigned snd_half_period(input int unsigned hz);
        return SND_CLK_HZ / (2 * hz);
    endfunction

endpackage

// File: rtl/snd_tone_gen.sv
// Square-wave tone generator. A requested half-period count is buffered and
// only swapped into the running counter at a half-period boundary (or at once
// from mute), so the speaker output never produces a short or long glitch.
//
// Request interface: snd_latch_max_count is a single-cycle strobe with no
// ready/back-pressure; snd_max_count is sampled only on edges where the strobe
// is high, and a newer strobe simply replaces any request still waiting.
module snd_tone_gen
    import snd_common::*;
#(
    parameter int unsigned COUNT_WIDTH = SND_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_sync,
    input  logic [COUNT_WIDTH-1:0] snd_max_count,
    input  logic                   snd_latch_max_count,
    output logic                   snd_out,
    output logic                   snd_active,
    output logic                   snd_pending
);

    logic [COUNT_WIDTH-1:0] r_active_count;
    logic [COUNT_WIDTH-1:0] r_pending_count;
    logic                   r_pending_valid;
    logic [COUNT_WIDTH-1:0] r_counter;
    logic                   r_snd_out;
    logic                   r_snd_active;

    logic w_playing;
    logic w_boundary;
    logic w_apply;

    // Boundary is the last clock of a half-period; apply swaps in the pending
    // count either there or immediately when nothing is playing.
    always_comb begin
        w_playing  = (r_active_count != '0);
        w_boundary = w_playing && (r_counter == (r_active_count - COUNT_WIDTH'(1)));
        w_apply    = r_pending_valid && (!w_playing || w_boundary);
    end

    // Request buffer: a strobe always wins over the clear-on-apply, so a latch
    // on the apply edge stays pending for the next boundary.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            r_pending_count <= '0;
            r_pending_valid <= 1'b0;
        end else if (snd_latch_max_count) begin
            r_pending_count <= snd_max_count;
            r_pending_valid <= 1'b1;
        end else if (w_apply) begin
            r_pending_valid <= 1'b0;
        end
    end

    // Half-period counter, applied count and the output square wave.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            r_active_count <= '0;
            r_counter      <= '0;
            r_snd_out      <= 1'b0;
            r_snd_active   <= 1'b0;
        end else if (w_apply) begin
            r_active_count <= r_pending_count;
            r_snd_active   <= (r_pending_count != '0);
            r_counter      <= '0;
            // Starting from mute or switching to mute begins low; otherwise
            // this is a normal boundary toggle.
            if (!w_playing || (r_pending_count == '0)) begin
                r_snd_out <= 1'b0;
            end else begin
                r_snd_out <= ~r_snd_out;
            end
        end else if (w_playing) begin
            if (w_boundary) begin
                r_counter <= '0;
                r_snd_out <= ~r_snd_out;
            end else begin
                r_counter <= r_counter + COUNT_WIDTH'(1);
            end
        end else begin
            r_counter <= '0;
            r_snd_out <= 1'b0;
        end
    end

    assign snd_out     = r_snd_out;
    assign snd_active  = r_snd_active;
    assign snd_pending = r_pending_valid;

endmodule
